// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: captures rising edges, masks with mie,
// and presents one committed request at a time to the core's INT_/mcause.
module irq_controller #(
  parameter int unsigned N_IRQ      = 16,
  parameter int unsigned CAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic [N_IRQ-1:0] pending_o
);

  localparam int unsigned SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_IRQ-1:0]   r_irq_prev;
  logic [N_IRQ-1:0]   r_pending;
  logic [SEL_W-1:0]   r_sel;
  logic               r_int;
  logic [31:0]        r_mcause;
  logic [N_IRQ-1:0]   r_ack;

  logic [N_IRQ-1:0]   w_edges;
  logic [N_IRQ-1:0]   w_elig;
  logic               w_any;
  logic [SEL_W-1:0]   w_low;
  logic [N_IRQ-1:0]   w_sel_onehot;
  logic [N_IRQ-1:0]   w_clr;
  logic [N_IRQ-1:0]   w_ack_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [31:0]        w_mcause_nxt;
  logic [N_IRQ-1:0]   w_pending_nxt;
  logic               w_unused_mie;

  assign w_unused_mie  = ^mie_i[31:N_IRQ];
  assign w_edges       = irq_i & ~r_irq_prev;
  assign w_elig        = r_pending & mie_i[N_IRQ-1:0];
  assign w_any         = |w_elig;
  assign w_sel_onehot  = N_IRQ'(1) << r_sel;
  // New edge wins over the acknowledge clear on the same line.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edges;

  // Lowest eligible index wins.
  always_comb begin
    w_low = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_low = SEL_W'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_mcause_nxt = r_mcause;
    w_clr        = '0;
    w_ack_nxt    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_sel_nxt    = w_low;
          w_mcause_nxt = {1'b1, 31'(CAUSE_BASE + 32'(w_low))};
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_rst_i) begin
          w_clr       = w_sel_onehot;
          w_ack_nxt   = w_sel_onehot;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= ST_IDLE;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_sel      <= '0;
      r_int      <= 1'b0;
      r_mcause   <= 32'h0;
      r_ack      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= irq_i;
      r_pending  <= w_pending_nxt;
      r_sel      <= w_sel_nxt;
      r_int      <= (w_state_nxt == ST_REQ);
      r_mcause   <= w_mcause_nxt;
      r_ack      <= w_ack_nxt;
    end
  end

  assign int_o     = r_int;
  assign mcause_o  = r_mcause;
  assign irq_ack_o = r_ack;
  assign pending_o = r_pending;

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller for the single-cycle RISC-V core. Latches rising edges on up to 31 external interrupt lines and masks them with the core's `mie` CSR. Presents one request at a time to the core's `INT_`/`mcause` inputs using fixed priority, and retires the request when the core pulses `INT_RST`. Sits between peripherals and `cpu_main`. Its outputs drive `INT_` and `mcause`; it takes `mie` and `INT_RST` from the core.

## Interface
- `N_IRQ`, default 16: number of interrupt lines, legal range 1..31.
- `CAUSE_BASE`, default 16: mcause code of line 0. Line i reports code `CAUSE_BASE + i`. `CAUSE_BASE + N_IRQ - 1` must be less than 2^31.
- `clk_i` input, 1 bit: single clock. All state changes on the rising edge.
- `arst_i` input, 1 bit: reset, asynchronous and active-high.
- `irq_i` input, N_IRQ bits: peripheral interrupt lines. Must already be synchronous to `clk_i`. Only rising edges matter.
- `mie_i` input, 32 bits: core `mie` CSR. Bit i enables line i. Bits N_IRQ..31 are ignored.
- `int_rst_i` input, 1 bit: core acknowledge (`INT_RST`). A 1-cycle pulse means the trap was taken.
- `int_o` output, 1 bit: interrupt request to the core (`INT_`).
- `mcause_o` output, 32 bits: cause value for the core. Equals `{1'b1, 31'(CAUSE_BASE + sel)}`.
- `irq_ack_o` output, N_IRQ bits: one-hot, 1-cycle pulse naming the line just serviced. Peripherals use it to clear their source.
- `pending_o` output, N_IRQ bits: current pending register, for debug.

## Operation
- Edge capture:
  - `irq_prev` registers `irq_i` every cycle.
  - `irq_i[i] & ~irq_prev[i]` sets `pending[i]`.
  - Level-high inputs without a new edge do not re-pend.
- Eligibility: `elig = pending & mie_i[N_IRQ-1:0]`.
- Masked lines stay pending. They become eligible as soon as `mie` enables them.
- Priority: lowest index wins.
- FSM with states IDLE, REQ, GAP:
  - IDLE: if `elig != 0`, latch `sel` = lowest set index, load `mcause_o`, go to REQ. Otherwise stay.
  - REQ: `int_o = 1`. Wait for `int_rst_i`. On `int_rst_i = 1`:
    - clear `pending[sel]`;
    - pulse `irq_ack_o[sel]`;
    - go to GAP.
  - GAP: one cycle with `int_o = 0`, then go to IDLE. This guarantees the core sees `INT_` fall between two requests.
- A request is committed once in REQ:
  - Clearing `mie_i[sel]` does not withdraw it.
  - A higher-priority line arriving does not preempt it.
- `int_rst_i` in IDLE or GAP is ignored. It has no effect on pending or outputs.
- Simultaneous set and clear of `pending[sel]` (new edge in the same cycle as the acknowledge): set wins, and the line is re-pended.
- `mcause_o` keeps its last loaded value outside REQ. It changes only on the IDLE→REQ transition.
- `pending_o` mirrors the pending register.

## Timing
- Reset (async assert, sampled release) sets:
  - state = IDLE;
  - `pending`, `irq_prev`, `int_o`, `irq_ack_o` = 0;
  - `mcause_o` = 32'h0;
  - `sel` = 0.
- Because `irq_prev` resets to 0, a line already high at reset release counts as one edge in the first cycle.
- Latency from `irq_i` rising to `int_o`:
  - edge sampled at clock k → `pending` set after k;
  - IDLE→REQ at clock k+1 → `int_o` = 1 after k+1.
  - Total: 2 cycles. Masked lines add the time until `mie` enables them.
- `int_o`, `mcause_o`, `irq_ack_o` are registered outputs with no combinational input-to-output path.
- Acknowledge sampled at clock a:
  - after a: `int_o` = 0, `irq_ack_o` pulses, state = GAP;
  - after a+1: state = IDLE;
  - after a+2: earliest next `int_o` = 1.
- `irq_ack_o` is high for exactly one cycle per serviced request.
- Reset asserted mid-REQ: `int_o` drops immediately (async). All pending are lost. No `irq_ack_o` is issued.

## Test plan
- Single line: `mie_i` = 32'h8, `irq_i[3]` rises at cycle 0 → `int_o` = 1 at cycle 2 with `mcause_o` = 32'h80000013. Pulse `int_rst_i` at cycle 5 → `irq_ack_o` = 16'h0008 for 1 cycle, `int_o` = 0 at cycle 6, `pending_o` = 0.
- Priority: lines 5 and 2 rise in the same cycle, `mie_i` = 32'hFFFF → first request has `mcause_o` = 32'h80000012. After acknowledge plus GAP, second request has `mcause_o` = 32'h80000015. Two `irq_ack_o` pulses total, in order 0x0004 then 0x0020.
- Masking: line 7 rises with `mie_i` = 0 → `int_o` stays 0 for 20 cycles and `pending_o[7]` = 1. Set `mie_i` = 32'h80 → `int_o` = 1 on the next cycle, `mcause_o` = 32'h80000017.
- Commitment: in REQ for line 1, clear `mie_i` and raise line 0 → `int_o` stays 1 and `mcause_o` stays 32'h80000011 until acknowledge. Line 0 is serviced next.
- Re-pend race: in REQ for line 4, a new `irq_i[4]` edge occurs in the same cycle as `int_rst_i` → `irq_ack_o[4]` pulses, `pending_o[4]` stays 1, and a second request for code 0x14 follows after GAP.
- Reset: hold `irq_i[0]` = 1 through reset and release → one request for code 0x10. Assert `arst_i` while `int_o` = 1 → `int_o`, `pending_o`, `mcause_o` = 0 immediately, with no `irq_ack_o` pulse.
